seq_subtractor_4bit: RTL and testbench

Bit-serial ripple subtractor, the inverse arithmetic path to the combinational 4-bit full adder. It computes Diff = A - B - Bin one bit per clock, LSB first, using a single full-adder cell and a borrow flip-flop. A start/busy/done handshake lets a controller or bench launch an operation and collect the result. Intended for area-constrained datapaths where a WIDTH-bit subtraction can take WIDTH+1 cycles.

---
 rtl/seq_subtractor_4bit.sv | 140 ++++++++++++++
 tb/tb_seq_subtractor_4bit.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/seq_subtractor_4bit.sv
// Bit-serial subtractor: Diff = A - B - Bin, one bit per clock, LSB first,
// built around a single borrow cell plus a borrow flop and start/busy/done handshake.
module seq_subtractor_4bit #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] Diff,
   output logic             Bout
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_r;
   state_t           state_next_s;
   logic [WIDTH-1:0] shift_a_r;
   logic [WIDTH-1:0] shift_b_r;
   logic [WIDTH-1:0] res_r;
   logic [WIDTH-1:0] res_next_s;
   logic [CNT_W-1:0] cnt_r;
   logic             br_r;
   logic             br_next_s;
   logic             d_s;
   logic             last_s;
   logic             busy_r;
   logic             done_r;
   logic [WIDTH-1:0] diff_r;
   logic             bout_r;

   // One-bit borrow cell; returns {borrow_out, difference}
   function automatic logic [1:0] sub_cell(input logic a, input logic b, input logic br);
      sub_cell = {(~a & b) | (~(a ^ b) & br), a ^ b ^ br};
   endfunction

   // Next-state decode and per-bit arithmetic
   always_comb begin
      state_next_s      = state_r;
      {br_next_s, d_s}  = sub_cell(shift_a_r[0], shift_b_r[0], br_r);
      res_next_s        = {d_s, res_r[WIDTH-1:1]};
      last_s            = (cnt_r == CNT_W'(WIDTH - 1));
      case (state_r)
         IDLE: begin
            if (start) begin
               state_next_s = RUN;
            end else begin
               state_next_s = IDLE;
            end
         end
         RUN: begin
            if (last_s) begin
               state_next_s = DONE;
            end else begin
               state_next_s = RUN;
            end
         end
         DONE:    state_next_s = IDLE;
         default: state_next_s = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Operand shifters, borrow flop, counter and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_a_r <= {WIDTH{1'b0}};
         shift_b_r <= {WIDTH{1'b0}};
         res_r     <= {WIDTH{1'b0}};
         cnt_r     <= {CNT_W{1'b0}};
         br_r      <= 1'b0;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
         diff_r    <= {WIDTH{1'b0}};
         bout_r    <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               done_r <= 1'b0;
               if (start) begin
                  shift_a_r <= A;
                  shift_b_r <= B;
                  br_r      <= Bin;
                  cnt_r     <= {CNT_W{1'b0}};
                  res_r     <= {WIDTH{1'b0}};
                  busy_r    <= 1'b1;
               end else begin
                  busy_r    <= 1'b0;
               end
            end
            RUN: begin
               res_r     <= res_next_s;
               shift_a_r <= {1'b0, shift_a_r[WIDTH-1:1]};
               shift_b_r <= {1'b0, shift_b_r[WIDTH-1:1]};
               br_r      <= br_next_s;
               cnt_r     <= cnt_r + CNT_W'(1);
               // Result and borrow are published only on the final bit
               if (last_s) begin
                  diff_r <= res_next_s;
                  bout_r <= br_next_s;
                  done_r <= 1'b1;
               end else begin
                  done_r <= 1'b0;
               end
            end
            DONE: begin
               done_r <= 1'b0;
               busy_r <= 1'b0;
            end
            default: begin
               done_r <= 1'b0;
               busy_r <= 1'b0;
            end
         endcase
      end
   end

   assign busy = busy_r;
   assign done = done_r;
   assign Diff = diff_r;
   assign Bout = bout_r;

endmodule

// File: tb/tb_seq_subtractor_4bit.sv
// Scoreboard bench for seq_subtractor_4bit: driver pushes reference results,
// a negedge monitor pops and compares whenever done is presented.
module tb_seq_subtractor_4bit;

   localparam int W     = 4;
   localparam int BOUND = 20;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [W-1:0] A;
   logic [W-1:0] B;
   logic         Bin;
   logic         busy;
   logic         done;
   logic [W-1:0] Diff;
   logic         Bout;

   int           vectors;
   int           miscompares;
   logic [W:0]   sb_q[$];
   logic         prev_done;

   seq_subtractor_4bit #(.WIDTH(W), .CNT_W(3)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .A     (A),
      .B     (B),
      .Bin   (Bin),
      .busy  (busy),
      .done  (done),
      .Diff  (Diff),
      .Bout  (Bout)
   );

   always #5 clk = ~clk;

   // Reference: plain integer subtraction, borrow is the sign of the result
   function automatic logic [W:0] ref_sub(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
      int r;
      r = int'(a) - int'(b) - int'(bi);
      ref_sub = {r[W-1:0], (r < 0)};
   endfunction

   task automatic check(input string name, input int act, input int exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: compare every done pulse against the scoreboard head
   always @(negedge clk) begin
      if (rst_n && done) begin
         check("done_width", int'(prev_done), 0);
         if (sb_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_done: got done=1 expected no pending result at %0t", $time);
         end else begin
            logic [W:0] exp;
            exp = sb_q.pop_front();
            check("diff", int'(Diff), int'(exp[W:1]));
            check("bout", int'(Bout), int'(exp[0]));
         end
      end
      prev_done = rst_n && done;
   end

   // Present an operation; returns #1 after the accepting edge
   task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
      A = a; B = b; Bin = bi; start = 1'b1;
      sb_q.push_back(ref_sub(a, b, bi));
      @(posedge clk); #1;
      start = 1'b0;
      A = W'($urandom); B = W'($urandom); Bin = 1'($urandom);
      check("busy_after_accept", int'(busy), 1);
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (!done && n < BOUND) begin
         @(posedge clk); #1;
         n++;
         check("busy_in_op", int'(busy), 1);
      end
      check("done_timeout", int'(n < BOUND), 1);
   endtask

   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
      int n;
      launch(a, b, bi);
      wait_done(n);
      check("latency", n, W);
      @(posedge clk); #1;
      check("busy_idle", int'(busy), 0);
      check("done_idle", int'(done), 0);
   endtask

   // Directed vectors: {A, B, Bin, Diff, Bout}
   logic [W-1:0] t_a [6] = '{4'b0111, 4'b0011, 4'b0011, 4'b1011, 4'b1001, 4'b0000};
   logic [W-1:0] t_b [6] = '{4'b0011, 4'b0100, 4'b0100, 4'b1101, 4'b0011, 4'b0000};
   logic         t_bi[6] = '{1'b0,    1'b0,    1'b1,    1'b1,    1'b1,    1'b1};
   logic [W-1:0] t_d [6] = '{4'b0100, 4'b1111, 4'b1110, 4'b1101, 4'b0101, 4'b1111};
   logic         t_bo[6] = '{1'b0,    1'b1,    1'b1,    1'b1,    1'b0,    1'b1};

   initial begin
      int n;
      clk = 1'b0; rst_n = 1'b0; start = 1'b0;
      A = 4'b0000; B = 4'b0000; Bin = 1'b0;
      vectors = 0; miscompares = 0; prev_done = 1'b0;

      #12;
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_diff", int'(Diff), 0);
      check("rst_bout", int'(Bout), 0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 6; i++) begin
         run_op(t_a[i], t_b[i], t_bi[i]);
         check("dir_diff", int'(Diff), int'(t_d[i]));
         check("dir_bout", int'(Bout), int'(t_bo[i]));
      end

      // Start during RUN must be ignored
      launch(4'b0111, 4'b0101, 1'b0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      A = 4'b1111; B = 4'b0000; Bin = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(n);
      for (int i = 0; i < W + 4; i++) begin
         @(posedge clk); #1;
         check("no_second_done", int'(done), 0);
      end
      check("ign_diff", int'(Diff), 4'b0010);
      check("ign_bout", int'(Bout), 0);

      // Asynchronous reset mid-operation
      run_op(4'b1001, 4'b0011, 1'b0);
      check("pre_rst_diff", int'(Diff), 4'b0110);
      launch(4'b1111, 4'b0001, 1'b0);
      @(posedge clk); #1;
      @(posedge clk); #2;
      rst_n = 1'b0;
      void'(sb_q.pop_back());
      #1;
      check("arst_busy", int'(busy), 0);
      check("arst_done", int'(done), 0);
      check("arst_diff", int'(Diff), 0);
      check("arst_bout", int'(Bout), 0);
      @(posedge clk); #1;
      check("arst_hold_busy", int'(busy), 0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      run_op(4'b1100, 4'b0101, 1'b1);
      check("post_rst_diff", int'(Diff), 4'b0110);
      check("post_rst_bout", int'(Bout), 0);

      // Randomized operations
      for (int i = 0; i < 25; i++) begin
         run_op(W'($urandom), W'($urandom), 1'($urandom));
      end

      // Start held high: relaunch every W+2 cycles
      A = W'($urandom); B = W'($urandom); Bin = 1'($urandom); start = 1'b1;
      sb_q.push_back(ref_sub(A, B, Bin));
      @(posedge clk); #1;
      for (int k = 0; k < 5; k++) begin
         if (k < 4) begin
            A = W'($urandom); B = W'($urandom); Bin = 1'($urandom);
            sb_q.push_back(ref_sub(A, B, Bin));
         end else begin
            start = 1'b0;
         end
         wait_done(n);
         check("b2b_latency", n, W);
         @(posedge clk); #1;
         check("b2b_idle_busy", int'(busy), 0);
         check("b2b_idle_done", int'(done), 0);
         @(posedge clk); #1;
         check("b2b_relaunch", int'(busy), (k < 4) ? 1 : 0);
      end

      repeat (3) @(posedge clk);
      check("sb_empty", sb_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
